// File: rtl/sample_frame_pkg.sv
// Shared constants and state encodings for the ADC sample-frame receiver.
package sample_frame_pkg;

    localparam int SYNC_BIT  = 7;
    localparam int RSVD_BIT  = 6;
    localparam int PAYLOAD_W = 6;
    localparam int SAMPLE_W  = 12;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic {
        EXP_HI,
        EXP_LO
    } dec_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling and byte FSM.
// byte_valid_o / frame_err_o are asserted combinationally in the stop-sample cycle.
module uart_byte_rx
    import sample_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             rx_meta_q, rx_sync_q;
    logic [1:0]       fill_q, fill_d;
    logic             armed_q, armed_d;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    // fill_q tracks when both synchroniser stages hold real pin samples, so the
    // reset value of 1 can never be mistaken for the line having been seen high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            fill_q    <= fill_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + ONE;
        bit_d        = bit_q;
        shift_d      = shift_q;
        fill_d       = {fill_q[0], 1'b1};
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (armed_q && !rx_sync_q) begin
                    state_d = START;
                    cnt_d   = ONE;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    if (!rx_sync_q) begin
                        state_d = DATA;
                        cnt_d   = ONE;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = ONE;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL) begin
                    byte_valid_o = rx_sync_q;
                    frame_err_o  = !rx_sync_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A start edge is only honoured after the line has been high in IDLE.
        armed_d = (state_d == IDLE) && fill_q[1] && rx_sync_q;
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/sample_frame_rx.sv
// Receives the ADC UART stream and decodes two-byte frames into 12-bit samples.
// CLK_FREQ / BAUD must give at least 4 clocks per bit.
module sample_frame_rx
    import sample_frame_pkg::*;
#(
    parameter int CLK_FREQ = 36_750_000,
    parameter int BAUD     = 115_200
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                uart_rx_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_valid_o,
    output logic                frame_err_o,
    output logic                sync_err_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_frame_err;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (uart_rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_byte_valid),
        .frame_err_o (rx_frame_err)
    );

    dec_state_t           dec_state_q, dec_state_d;
    logic [PAYLOAD_W-1:0] hi_q, hi_d;
    logic [SAMPLE_W-1:0]  sample_q, sample_d;
    logic                 sample_valid_q, sample_valid_d;
    logic                 sync_err_q, sync_err_d;
    logic                 frame_err_q, frame_err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_state_q    <= EXP_HI;
            hi_q           <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            sync_err_q     <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            dec_state_q    <= dec_state_d;
            hi_q           <= hi_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sync_err_q     <= sync_err_d;
            frame_err_q    <= frame_err_d;
        end
    end

    // A framing error leaves the decoder untouched; only good bytes advance it.
    always_comb begin
        dec_state_d    = dec_state_q;
        hi_d           = hi_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        sync_err_d     = 1'b0;
        frame_err_d    = rx_frame_err;

        if (rx_byte_valid) begin
            if (rx_byte[RSVD_BIT]) begin
                sync_err_d  = 1'b1;
                dec_state_d = EXP_HI;
            end else if (rx_byte[SYNC_BIT]) begin
                // A second hi byte orphans the first but still starts a new frame.
                sync_err_d  = (dec_state_q == EXP_LO);
                hi_d        = rx_byte[PAYLOAD_W-1:0];
                dec_state_d = EXP_LO;
            end else if (dec_state_q == EXP_LO) begin
                sample_d       = {hi_q, rx_byte[PAYLOAD_W-1:0]};
                sample_valid_d = 1'b1;
                dec_state_d    = EXP_HI;
            end else begin
                sync_err_d = 1'b1;
            end
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign sync_err_o     = sync_err_q;
    assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_sample_frame_rx.sv
// Directed and randomized byte streams for sample_frame_rx, checked against an
// event-level model of the frame rules and the pin-to-pulse latency.
module tb_sample_frame_rx;

    localparam int CPB = 10;
    // Pin change seen at the next edge, two synchroniser stages, stop sample at
    // t0 + CPB/2 + 9*CPB, then one registered decoder cycle.
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    localparam int EV_SAMPLE = 0;
    localparam int EV_SYNC   = 1;
    localparam int EV_FRAME  = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        uart_rx_i;
    logic [11:0] sample_o;
    logic        sample_valid_o;
    logic        frame_err_o;
    logic        sync_err_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];

    // Reference decoder state
    bit m_exp_lo = 1'b0;
    int m_hi     = 0;
    int m_last   = 0;

    sample_frame_rx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .uart_rx_i     (uart_rx_i),
        .sample_o      (sample_o),
        .sample_valid_o(sample_valid_o),
        .frame_err_o   (frame_err_o),
        .sync_err_o    (sync_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (sample_valid_o) obs_q.push_back('{EV_SAMPLE, int'(sample_o), cyc});
            if (sync_err_o)     obs_q.push_back('{EV_SYNC, 0, cyc});
            if (frame_err_o)    obs_q.push_back('{EV_FRAME, 0, cyc});
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_exp_lo = 1'b0;
        m_hi     = 0;
        m_last   = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int k);
        int t;
        t = k + LAT;
        if (!stop_ok) begin
            exp_q.push_back('{EV_FRAME, 0, t});
        end else if (b[6]) begin
            exp_q.push_back('{EV_SYNC, 0, t});
            m_exp_lo = 1'b0;
        end else if (b[7]) begin
            if (m_exp_lo) exp_q.push_back('{EV_SYNC, 0, t});
            m_hi     = int'(b[5:0]);
            m_exp_lo = 1'b1;
        end else if (m_exp_lo) begin
            m_last = m_hi * 64 + int'(b[5:0]);
            exp_q.push_back('{EV_SAMPLE, m_last, t});
            m_exp_lo = 1'b0;
        end else begin
            exp_q.push_back('{EV_SYNC, 0, t});
        end
    endtask

    // Entered and left #1 after a rising edge.
    task automatic drive(input logic v, input int n);
        uart_rx_i = v;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        model_byte(b, stop_ok, cyc);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        if (stop_ok) drive(1'b1, CPB);
        else         drive(1'b0, 2 * CPB);
        drive(1'b1, gap);
    endtask

    task automatic glitch();
        drive(1'b0, 3);
        drive(1'b1, 2 * CPB);
    endtask

    task automatic flush_and_compare(input string phase);
        int n;
        drive(1'b1, LAT + 2 * CPB);
        check({phase, ":ev_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({phase, ":ev_kind"}, obs_q[i].kind, exp_q[i].kind);
            check({phase, ":ev_val"},  obs_q[i].val,  exp_q[i].val);
            check({phase, ":ev_cyc"},  obs_q[i].cyc,  exp_q[i].cyc);
        end
        check({phase, ":sample_hold"}, int'(sample_o), m_last);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [11:0] s;
        logic [7:0]  rb;
        int          kind;

        uart_rx_i = 1'b1;
        rst_i     = 1'b1;
        @(negedge clk);
        check("rst:sample", int'(sample_o), 0);
        check("rst:pulses", int'({sample_valid_o, sync_err_o, frame_err_o}), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        drive(1'b1, 20);

        // Basic frame
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h3C, 1'b1, 5);
        flush_and_compare("basic");

        // Back-to-back frames, no idle
        send_byte(8'hBF, 1'b1, 0);
        send_byte(8'h3F, 1'b1, 0);
        send_byte(8'h80, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        flush_and_compare("b2b");

        // Lone low byte, then a good frame
        send_byte(8'h3C, 1'b1, 3);
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h3C, 1'b1, 0);
        flush_and_compare("lone_lo");

        // Orphaned hi byte
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h95, 1'b1, 0);
        send_byte(8'h01, 1'b1, 0);
        flush_and_compare("orphan_hi");

        // Bad stop bit and a false start glitch
        send_byte(8'hAA, 1'b0, 5);
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h3C, 1'b1, 4);
        glitch();
        flush_and_compare("frame_err");

        // Reserved bit set mid-frame
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h7F, 1'b1, 0);
        send_byte(8'h15, 1'b1, 0);
        flush_and_compare("rsvd");

        // Reset in the middle of byte B, line held low across release
        send_byte(8'hAA, 1'b1, 0);
        drive(1'b0, CPB);
        drive(1'b0, CPB + 4);
        rst_i = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst:sample", int'(sample_o), 0);
            check("midrst:pulses", int'({sample_valid_o, sync_err_o, frame_err_o}), 0);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        drive(1'b0, 6);
        drive(1'b1, 3 * CPB);
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h3C, 1'b1, 0);
        flush_and_compare("reset");

        // Randomized mix of frames, stray bytes, framing errors and glitches
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1, 2: begin
                    s = 12'($urandom);
                    send_byte({2'b10, s[11:6]}, 1'b1, $urandom_range(0, 12));
                    send_byte({2'b00, s[5:0]}, 1'b1, $urandom_range(0, 12));
                end
                3, 4: begin
                    rb = 8'($urandom);
                    send_byte(rb, 1'b1, $urandom_range(0, 12));
                end
                5: begin
                    rb = 8'($urandom);
                    send_byte(rb, 1'b0, $urandom_range(3, 12));
                end
                default: glitch();
            endcase
        end
        flush_and_compare("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_frame_rx.md
# sample_frame_rx

Host-side receiver for the ADC sample stream. It deserialises the 8N1 UART byte stream that the readout logic sends and decodes two-byte sample frames back into 12-bit conversion results. It serves as the loopback checker on the FPGA and as the front end of a second board consuming ADC data. It sits on the PLL clock domain, driven from an external `uart_rx_i` pin.

## Interface
- `CLK_FREQ`, 36_750_000: clock frequency in Hz.
- `BAUD`, 115_200: line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer floor; must be ≥ 4).
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `uart_rx_i`  in  1  asynchronous serial input; idle high.
- `sample_o`  out  12  last decoded sample; holds until the next valid frame.
- `sample_valid_o`  out  1  one-cycle pulse; `sample_o` is new this cycle.
- `frame_err_o`  out  1  one-cycle pulse; stop bit sampled low.
- `sync_err_o`  out  1  one-cycle pulse; frame marker violation.

## Operation
- Frame format, two bytes, high byte first:
  - A = `{1'b1, 1'b0, s[11:6]}`.
  - B = `{1'b0, 1'b0, s[5:0]}`.
  - Bit 7 is the sync marker. Bit 6 is reserved and must be 0.
- Input conditioning: 2-FF synchroniser on `uart_rx_i` (reset value 1). A falling edge is detected on the synchronised signal.
- Byte RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: arms only while the line is high. A falling edge loads the bit counter and enters START.
  - START: at `CLKS_PER_BIT/2` cycles, re-sample the line. If low, enter DATA. If high, this is a false start: return to IDLE with no strobe.
  - DATA: sample 8 bits LSB first, each `CLKS_PER_BIT` cycles apart, then enter STOP.
  - STOP: sample one bit period later.
    - High: byte strobe, then IDLE.
    - Low: `frame_err_o` pulse, byte discarded, then IDLE. IDLE waits for the line to return high.
- Decoder FSM: EXP_HI, EXP_LO. It acts on each byte strobe.
  - Byte with bit6 = 1, in either state: `sync_err_o`, discard, go to EXP_HI.
  - Bit7 = 1 in EXP_HI: latch `hi <= byte[5:0]`, go to EXP_LO.
  - Bit7 = 1 in EXP_LO: `sync_err_o`, because the previous hi byte is orphaned. Latch the new hi and stay in EXP_LO.
  - Bit7 = 0 in EXP_LO: `sample_o <= {hi, byte[5:0]}`, `sample_valid_o` pulse, go to EXP_HI.
  - Bit7 = 0 in EXP_HI: `sync_err_o`, discard.
- `frame_err_o` does not change the decoder state.

## Timing
- Reset values:
  - States: IDLE, EXP_HI.
  - Outputs: `sample_o = 0`, all pulses 0.
  - Internal: `hi = 0`, synchroniser = 1.
- Reset mid-byte or mid-frame aborts immediately. No pulse is emitted. The receiver re-arms only after the line is seen high.
- Let t0 be the cycle the synchronised falling edge is detected.
  - Data bit n (0..7) is sampled at t0 + `CLKS_PER_BIT/2` + (n+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- The byte strobe is asserted in the stop-sample cycle. Decoder outputs and pulses are registered one cycle later.
- Pin-to-output latency is 2 synchroniser cycles plus the above.
- Back-to-back bytes with zero idle time must be accepted. A new start edge is detectable in the cycle after the stop sample.
- At most one of `sample_valid_o` or `sync_err_o` fires per byte. `frame_err_o` fires alone.

## Structure
- Package `sample_frame_pkg`:
  - `SYNC_BIT = 7`, `RSVD_BIT = 6`, `PAYLOAD_W = 6`, `SAMPLE_W = 12`.
  - Enums `rx_state_t` {IDLE, START, DATA, STOP} and `dec_state_t` {EXP_HI, EXP_LO}.
- Sub-module `uart_byte_rx`: synchroniser, bit timing and byte FSM. Outputs `byte_o[7:0]`, `byte_valid_o` and `frame_err_o`.
- The decoder lives in the top module.

## Test plan
All scenarios use `CLK_FREQ` = 1_000_000 and `BAUD` = 100_000 (`CLKS_PER_BIT` = 10).
- Send 0xAA, 0x3C → one `sample_valid_o` pulse, `sample_o` = 0xABC. No error pulses.
- Send 0xBF, 0x3F, then 0x80, 0x00 with zero idle time between them → samples 0xFFF then 0x000, 20 bit periods apart.
- Send 0x3C alone, then 0xAA, 0x3C → `sync_err_o` on the first byte, then sample 0xABC.
- Send 0xAA, 0x95 (sync bit 1 again), 0x01 → `sync_err_o` on the second byte, then sample 0x541 (hi = 0x15).
- Send 0xAA with the stop bit held low for 2 bit periods, then 0xAA, 0x3C → `frame_err_o` once, no sample from the bad byte, then sample 0xABC. Also send a 3-cycle low glitch → no strobe (false start).
- Assert `rst_i` mid-DATA of byte B after valid byte A, then send 0xAA, 0x3C → no pulses during or after reset until sample 0xABC. `sample_o` reads 0 during reset.
